// File: rtl/rom_reader.sv
// Burst read sequencer for a registered-output ROM: walks base..base+len with wrap, streams words out.
// Latency: start at edge N -> first rom_en in cycle N..N+1, first out_valid from edge N+2.
// Backpressure: credit-gated issue into a 2-entry buffer; rom_en drops when no credit, no word lost.
module rom_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  // words still to issue; one bit wider so a full 2^ADDR_W burst fits
  logic [ADDR_W:0]   remaining;
  // a read was issued at the previous edge, so rom_data is meaningful now
  logic              inflight;

  logic [DATA_W-1:0] buf_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        occ;

  logic              pop;
  logic              cap;
  logic [2:0]        committed;

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign cap       = inflight;

  // Credits: words already buffered plus the one in flight must leave room,
  // and a pop this cycle frees a slot immediately.
  assign committed = {1'b0, occ} + {2'b00, inflight};
  assign rom_en    = (state == RUN) && (remaining != '0) &&
                     (committed < (3'd2 + {2'b00, pop}));

  // Sequencer FSM: address walk, remaining count, in-flight tracking, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rom_en;
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr  <= base;
            remaining <= {1'b0, len} + (ADDR_W+1)'(1);
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (rom_en) begin
            rom_addr  <= rom_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // last word leaves when nothing is in flight and it is the only one buffered
          if (!inflight && (occ == 2'd1) && pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer: capture the ROM word one cycle after issue, pop on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      if (cap) begin
        buf_mem[wr_ptr] <= rom_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({cap, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // The credit rule must never let a capture land on a full buffer without a pop
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(cap && !pop && (occ == 2'd2)));

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: behavioural ROM plus expected word sequences built from base/len.
module tb_rom_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] base;
  logic [3:0] len;
  logic       busy;
  logic       done;
  logic [3:0] rom_addr;
  logic       rom_en;
  logic [3:0] rom_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int total;
  int bad;

  logic [3:0] rom_mem [16];

  // monitor state
  int         cyc;
  logic [3:0] addr_q[$];
  int         issue_cyc_q[$];
  logic [3:0] data_q[$];
  int         pop_cyc_q[$];
  int         done_cnt;
  int         done_cyc;
  int         hold_err;
  int         valid_seen;
  logic       prev_stall;
  logic [3:0] prev_data;

  rom_reader #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: registered read; garbage on cycles without a read request
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
    else        rom_data <= 4'($urandom);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observe away from the edge: what will happen at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        addr_q.push_back(rom_addr);
        issue_cyc_q.push_back(cyc + 1);
      end
      if (out_valid && out_ready) begin
        data_q.push_back(out_data);
        pop_cyc_q.push_back(cyc + 1);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (out_valid) valid_seen = valid_seen + 1;
      if (prev_stall && !(out_valid && out_data == prev_data)) hold_err = hold_err + 1;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    addr_q.delete();
    issue_cyc_q.delete();
    data_q.delete();
    pop_cyc_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    hold_err   = 0;
    valid_seen = 0;
  endtask

  // drives a one-cycle start; returns just after the accepting edge
  task automatic start_burst(input logic [3:0] b, input logic [3:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (rom_en !== 1'b0)    begin bad++; $display("FAIL reset_rom_en got=%b want=0", rom_en); end
    total++; if (rom_addr !== 4'd0)  begin bad++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 4'd0)  begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full();
    logic [3:0] exp;
    out_ready = 1'b1;
    clear_mon();
    start_burst(4'd0, 4'd15);
    total++; if (rom_en !== 1'b1 || rom_addr !== 4'd0) begin
      bad++; $display("FAIL full_first_issue got en=%b addr=%0d want en=1 addr=0", rom_en, rom_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b want=1", busy); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_valid_early got=%b want=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== rom_mem[0]) begin
      bad++; $display("FAIL full_first_word got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, rom_mem[0]); end
    wait_done(60);
    total++; if (addr_q.size() != 16) begin bad++; $display("FAIL full_issue_count got=%0d want=16", addr_q.size()); end
    total++; if (data_q.size() != 16) begin bad++; $display("FAIL full_word_count got=%0d want=16", data_q.size()); end
    for (int i = 0; i < 16 && i < addr_q.size() && i < data_q.size(); i++) begin
      exp = 4'(i);
      total++; if (addr_q[i] !== exp) begin bad++; $display("FAIL full_addr[%0d] got=%0d want=%0d", i, addr_q[i], exp); end
      total++; if (data_q[i] !== rom_mem[exp]) begin bad++; $display("FAIL full_data[%0d] got=%0d want=%0d", i, data_q[i], rom_mem[exp]); end
      if (i > 0) begin
        total++; if (issue_cyc_q[i] != issue_cyc_q[i-1] + 1) begin bad++; $display("FAIL full_issue_gap[%0d] got=%0d want=1", i, issue_cyc_q[i] - issue_cyc_q[i-1]); end
        total++; if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) begin bad++; $display("FAIL full_pop_gap[%0d] got=%0d want=1", i, pop_cyc_q[i] - pop_cyc_q[i-1]); end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
    if (pop_cyc_q.size() > 0) begin
      total++; if (done_cyc != pop_cyc_q[pop_cyc_q.size()-1]) begin
        bad++; $display("FAIL full_done_timing got=%0d want=%0d", done_cyc, pop_cyc_q[pop_cyc_q.size()-1]); end
    end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a [4];
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
    out_ready = 1'b1;
    clear_mon();
    start_burst(4'd14, 4'd3);
    wait_done(40);
    total++; if (addr_q.size() != 4 || data_q.size() != 4) begin
      bad++; $display("FAIL wrap_count got a=%0d d=%0d want 4", addr_q.size(), data_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size() && i < data_q.size(); i++) begin
      total++; if (addr_q[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", i, addr_q[i], exp_a[i]); end
      total++; if (data_q[i] !== rom_mem[exp_a[i]]) begin bad++; $display("FAIL wrap_data[%0d] got=%0d want=%0d", i, data_q[i], rom_mem[exp_a[i]]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int stall_en;
    out_ready = 1'b0;
    clear_mon();
    start_burst(4'd5, 4'd7);
    for (int i = 0; i < 10 && !out_valid; i++) step();
    stall_en = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rom_en) stall_en++;
    end
    total++; if (addr_q.size() != 2) begin bad++; $display("FAIL bp_issued_ahead got=%0d want=2", addr_q.size()); end
    total++; if (stall_en != 0) begin bad++; $display("FAIL bp_rom_en_stalled got=%0d want=0", stall_en); end
    total++; if (out_valid !== 1'b1 || out_data !== rom_mem[5]) begin
      bad++; $display("FAIL bp_head got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, rom_mem[5]); end
    out_ready = 1'b1;
    #1;
    total++; if (rom_en !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b want=1", rom_en); end
    wait_done(60);
    total++; if (data_q.size() != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", data_q.size()); end
    for (int i = 0; i < 8 && i < data_q.size(); i++) begin
      total++; if (data_q[i] !== rom_mem[4'(5 + i)]) begin
        bad++; $display("FAIL bp_data[%0d] got=%0d want=%0d", i, data_q[i], rom_mem[4'(5 + i)]); end
    end
    total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    clear_mon();
    start_burst(4'd9, 4'd0);
    start = 1'b1; base = 4'd2; len = 4'd5;
    step();
    start = 1'b0;
    wait_done(30);
    repeat (4) step();
    total++; if (data_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", data_q.size()); end
    if (data_q.size() > 0) begin
      total++; if (data_q[0] !== rom_mem[9]) begin bad++; $display("FAIL single_data got=%0d want=%0d", data_q[0], rom_mem[9]); end
    end
    total++; if (addr_q.size() != 1) begin bad++; $display("FAIL single_issues got=%0d want=1", addr_q.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    clear_mon();
    start_burst(4'd0, 4'd15);
    for (int i = 0; i < 20 && data_q.size() < 3; i++) step();
    rst = 1'b1;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0 || rom_en !== 1'b0 || rom_addr !== 4'd0 ||
                 out_valid !== 1'b0 || out_data !== 4'd0) begin
      bad++; $display("FAIL rmid_reset_vals got busy=%b done=%b en=%b addr=%0d v=%b d=%0d want all 0",
                      busy, done, rom_en, rom_addr, out_valid, out_data); end
    rst = 1'b0;
    clear_mon();
    repeat (5) step();
    total++; if (valid_seen != 0) begin bad++; $display("FAIL rmid_no_valid got=%0d want=0", valid_seen); end
    clear_mon();
    start_burst(4'd3, 4'd1);
    wait_done(30);
    total++; if (data_q.size() != 2) begin bad++; $display("FAIL rmid_count got=%0d want=2", data_q.size()); end
    for (int i = 0; i < 2 && i < data_q.size(); i++) begin
      total++; if (data_q[i] !== rom_mem[4'(3 + i)]) begin
        bad++; $display("FAIL rmid_data[%0d] got=%0d want=%0d", i, data_q[i], rom_mem[4'(3 + i)]); end
    end
  endtask

  task automatic test_rst_start();
    int en_cnt;
    int busy_cnt;
    out_ready = 1'b1;
    clear_mon();
    rst = 1'b1; start = 1'b1; base = 4'd7; len = 4'd4;
    step();
    rst = 1'b0; start = 1'b0;
    en_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (rom_en) en_cnt++;
      if (busy) busy_cnt++;
      step();
    end
    total++; if (busy_cnt != 0) begin bad++; $display("FAIL rs_busy got=%0d want=0", busy_cnt); end
    total++; if (en_cnt != 0) begin bad++; $display("FAIL rs_rom_en got=%0d want=0", en_cnt); end
    total++; if (valid_seen != 0 || data_q.size() != 0) begin
      bad++; $display("FAIL rs_output got v=%0d d=%0d want 0", valid_seen, data_q.size()); end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic [3:0] l;
    logic [3:0] exp_q[$];
    for (int a = 0; a < 16; a++) rom_mem[a] = 4'($urandom);
    for (int t = 0; t < 8; t++) begin
      b = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15));
      exp_q.delete();
      for (int i = 0; i <= int'(l); i++) exp_q.push_back(rom_mem[4'(int'(b) + i)]);
      out_ready = 1'($urandom);
      clear_mon();
      start_burst(b, l);
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      out_ready = 1'b1;
      step();
      total++; if (data_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", t, data_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < data_q.size(); i++) begin
        total++; if (data_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rnd%0d_data[%0d] got=%0d want=%0d", t, i, data_q[i], exp_q[i]); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL rnd%0d_done got=%0d want=1", t, done_cnt); end
      total++; if (hold_err != 0) begin bad++; $display("FAIL rnd%0d_hold got=%0d want=0", t, hold_err); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = 4'd0;
    rst = 1'b1; start = 1'b0; base = 4'd0; len = 4'd0; out_ready = 1'b0;
    for (int a = 0; a < 16; a++) rom_mem[a] = 4'(a);
    clear_mon();
    #1;
    test_reset();
    test_full();
    test_wrap();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_rst_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
